// File: rtl/wb_arb2_pkg.sv
// rtl/wb_arb2_pkg.sv - shared types and helpers for the 2:1 pipelined Wishbone arbiter
package wb_arb2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [3:0] SEL_ALL = 4'hF;

  // Returns the port to grant from IDLE; on a tie the port that did not own the bus last wins.
  function automatic logic pick_port(input logic m0_cyc, input logic m1_cyc, input logic last);
    if (m0_cyc && m1_cyc) begin
      return ~last;
    end
    return m1_cyc;
  endfunction

endpackage

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - 2:1 pipelined Wishbone arbiter sharing one slave between imem (port 0) and dmem (port 1)
// Grant is held for a whole bus cycle and until every accepted request has been acked.
module wb_arb2
  import wb_arb2_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_stall_o,
  output logic        m0_ack_o,

  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [2:0]  m1_cti_i,
  input  logic        m1_cyc_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_stall_o,
  output logic        m1_ack_o,

  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic [2:0]  s_cti_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_stall_i,
  input  logic        s_ack_i,

  output logic        err_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic cnt_full;
  logic cnt_zero;
  logic accept;
  logic ack_ok;

  assign cnt_full = (count_q == MAX_CNT);
  assign cnt_zero = (count_q == '0);
  assign accept   = s_stb_o & ~s_stall_i;
  // An ack with nothing outstanding is stray: it is neither counted nor routed to a master.
  assign ack_ok   = s_ack_i & ~cnt_zero;

  always_comb begin
    count_d = count_q;
    if (accept && !ack_ok) begin
      count_d = count_q + 1'b1;
    end else if (!accept && ack_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  assign err_d = err_q | (s_ack_i & cnt_zero);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          state_d = pick_port(m0_cyc_i, m1_cyc_i, last_q) ? ST_GNT1 : ST_GNT0;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i && (count_d == '0)) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i && (count_d == '0)) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data fans out to both masters; only the owner's ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign err_o    = err_q;

  always_comb begin
    s_addr_o   = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;
    s_cti_o    = '0;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    case (state_q)
      ST_GNT0: begin
        s_addr_o   = m0_addr_i;
        s_sel_o    = SEL_ALL;
        s_cti_o    = m0_cti_i;
        s_cyc_o    = 1'b1;
        s_stb_o    = m0_stb_i & ~cnt_full;
        m0_stall_o = s_stall_i | cnt_full;
        m0_ack_o   = ack_ok;
      end
      ST_GNT1: begin
        s_addr_o   = m1_addr_i;
        s_dat_o    = m1_dat_i;
        s_sel_o    = m1_sel_i;
        s_cti_o    = m1_cti_i;
        s_cyc_o    = 1'b1;
        s_stb_o    = m1_stb_i & ~cnt_full;
        s_we_o     = m1_we_i;
        m1_stall_o = s_stall_i | cnt_full;
        m1_ack_o   = ack_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - directed self-checking bench for wb_arb2 with MAX_OUTSTANDING=2
module tb_wb_arb2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_addr_i;
  logic [2:0]  m0_cti_i;
  logic        m0_cyc_i, m0_stb_i;
  logic [31:0] m0_dat_o;
  logic        m0_stall_o, m0_ack_o;
  logic [31:0] m1_addr_i, m1_dat_i;
  logic [3:0]  m1_sel_i;
  logic [2:0]  m1_cti_i;
  logic        m1_cyc_i, m1_we_i, m1_stb_i;
  logic [31:0] m1_dat_o;
  logic        m1_stall_o, m1_ack_o;
  logic [31:0] s_addr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [2:0]  s_cti_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_dat_i;
  logic        s_stall_i, s_ack_i;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  wb_arb2 #(.MAX_OUTSTANDING(2), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_addr_i(m0_addr_i), .m0_cti_i(m0_cti_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
    .m1_addr_i(m1_addr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
    .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_stall_i(s_stall_i), .s_ack_i(s_ack_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    m0_addr_i = '0; m0_cti_i = '0; m0_cyc_i = 0; m0_stb_i = 0;
    m1_addr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_cti_i = '0;
    m1_cyc_i = 0; m1_we_i = 0; m1_stb_i = 0;
    s_dat_i = '0; s_stall_i = 0; s_ack_i = 0;

    // reset state
    tick(); tick(); #1;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_s_sel", s_sel_o, 0);
    chk("rst_m0_stall", m0_stall_o, 1);
    chk("rst_m1_stall", m1_stall_o, 1);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;

    // single m0 read at address 0
    tick();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h0; #1;
    chk("t1_idle_cyc", s_cyc_o, 0);
    chk("t1_idle_stall", m0_stall_o, 1);
    tick(); #1;
    chk("t1_s_cyc", s_cyc_o, 1);
    chk("t1_s_stb", s_stb_o, 1);
    chk("t1_s_addr", s_addr_o, 32'h0);
    chk("t1_s_we", s_we_o, 0);
    chk("t1_s_sel", s_sel_o, 4'hF);
    chk("t1_s_dat", s_dat_o, 0);
    chk("t1_m0_stall", m0_stall_o, 0);
    chk("t1_m1_stall", m1_stall_o, 1);
    tick();
    m0_stb_i = 0; m0_cyc_i = 0; s_ack_i = 1; s_dat_i = 32'hCAFE0001; #1;
    chk("t1_m0_ack", m0_ack_o, 1);
    chk("t1_m0_dat", m0_dat_o, 32'hCAFE0001);
    chk("t1_m1_ack", m1_ack_o, 0);
    tick();
    s_ack_i = 0; #1;
    chk("t1_release", s_cyc_o, 0);

    // both request together: port 1 first, then port 0
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h100;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h200; m1_we_i = 1; m1_dat_i = 32'hAA; m1_sel_i = 4'h3;
    #1;
    chk("t2_idle_cyc", s_cyc_o, 0);
    tick(); #1;
    chk("t2_s_addr1", s_addr_o, 32'h200);
    chk("t2_s_we1", s_we_o, 1);
    chk("t2_s_sel1", s_sel_o, 4'h3);
    chk("t2_s_dat1", s_dat_o, 32'hAA);
    chk("t2_m0_stall", m0_stall_o, 1);
    chk("t2_m1_stall", m1_stall_o, 0);
    tick();
    m1_stb_i = 0; m1_cyc_i = 0; #1;
    chk("t2_hold_cyc", s_cyc_o, 1);
    chk("t2_hold_stb", s_stb_o, 0);
    tick();
    s_ack_i = 1; s_dat_i = 32'h5; #1;
    chk("t2_m1_ack", m1_ack_o, 1);
    chk("t2_m0_noack", m0_ack_o, 0);
    tick();
    s_ack_i = 0; #1;
    chk("t2_idle_gap", s_cyc_o, 0);
    chk("t2_idle_m0_stall", m0_stall_o, 1);
    tick(); #1;
    chk("t2_s_addr0", s_addr_o, 32'h100);
    chk("t2_s_we0", s_we_o, 0);
    chk("t2_s_sel0", s_sel_o, 4'hF);
    chk("t2_s_dat0", s_dat_o, 0);
    chk("t2_m0_stall_gnt", m0_stall_o, 0);
    tick();
    m0_stb_i = 0; m0_cyc_i = 0; s_ack_i = 1; #1;
    chk("t2_m0_ack", m0_ack_o, 1);
    tick();
    s_ack_i = 0;

    // m1 burst of 4 writes, stall toggling, outstanding limit 2
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF; m1_dat_i = 32'h11; s_stall_i = 1;
    tick(); #1;
    chk("b0_stb", s_stb_o, 1);
    chk("b0_stall", m1_stall_o, 1);
    tick();
    s_stall_i = 0; #1;
    chk("b1_stall", m1_stall_o, 0);
    chk("b1_dat", s_dat_o, 32'h11);
    tick();
    m1_dat_i = 32'h22; s_stall_i = 1; #1;
    chk("b2_stall", m1_stall_o, 1);
    tick();
    s_stall_i = 0; #1;
    chk("b3_dat", s_dat_o, 32'h22);
    chk("b3_stall", m1_stall_o, 0);
    tick();
    m1_dat_i = 32'h33; #1;
    chk("b4_full_stb", s_stb_o, 0);
    chk("b4_full_stall", m1_stall_o, 1);
    tick();
    s_ack_i = 1; #1;
    chk("b5_ack", m1_ack_o, 1);
    chk("b5_stb", s_stb_o, 0);
    tick();
    s_ack_i = 0; #1;
    chk("b6_stb", s_stb_o, 1);
    chk("b6_stall", m1_stall_o, 0);
    tick();
    m1_dat_i = 32'h44; s_ack_i = 1; #1;
    chk("b7_stb", s_stb_o, 0);
    chk("b7_ack", m1_ack_o, 1);
    tick(); #1;
    chk("b8_stb", s_stb_o, 1);
    chk("b8_dat", s_dat_o, 32'h44);
    chk("b8_ack", m1_ack_o, 1);
    tick();
    m1_stb_i = 0; #1;
    chk("b9_ack", m1_ack_o, 1);
    tick();
    s_ack_i = 0; m1_stb_i = 1; m1_dat_i = 32'h55; #1;
    chk("b10_cyc", s_cyc_o, 1);
    chk("b10_stall", m1_stall_o, 0);
    chk("b10_err", err_o, 0);

    // owner drops cyc with two outstanding
    tick(); #1;
    chk("d0_stb", s_stb_o, 1);
    tick();
    m1_stb_i = 0; m1_cyc_i = 0; #1;
    chk("d1_hold", s_cyc_o, 1);
    chk("d1_m0_stall", m0_stall_o, 1);
    tick();
    s_ack_i = 1; #1;
    chk("d2_ack", m1_ack_o, 1);
    chk("d2_hold", s_cyc_o, 1);
    tick(); #1;
    chk("d3_ack", m1_ack_o, 1);
    tick();
    s_ack_i = 0; #1;
    chk("d4_idle", s_cyc_o, 0);
    chk("d4_err", err_o, 0);

    // stray ack in IDLE
    s_ack_i = 1; #1;
    chk("e_m0_ack", m0_ack_o, 0);
    chk("e_m1_ack", m1_ack_o, 0);
    tick();
    s_ack_i = 0; #1;
    chk("e_err", err_o, 1);

    // reset in the middle of a grant
    m0_cyc_i = 1; m0_stb_i = 1;
    tick(); tick();
    m0_stb_i = 0; #1;
    chk("r_pre_cyc", s_cyc_o, 1);
    rst_i = 1; #1;
    chk("r_s_cyc", s_cyc_o, 0);
    chk("r_s_stb", s_stb_o, 0);
    chk("r_err", err_o, 0);
    chk("r_m0_stall", m0_stall_o, 1);
    chk("r_m0_ack", m0_ack_o, 0);
    m0_cyc_i = 0;
    tick();
    rst_i = 0;
    m0_cyc_i = 1; m1_cyc_i = 1;
    tick(); #1;
    chk("r_tie_cyc", s_cyc_o, 1);
    chk("r_tie_m1_stall", m1_stall_o, 0);
    chk("r_tie_m0_stall", m0_stall_o, 1);
    m0_cyc_i = 0; m1_cyc_i = 0;
    tick(); #1;
    chk("r_cnt_clear", s_cyc_o, 0);
    chk("r_err_after", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
